ps2_kbd_cmd_sequencer: RTL and testbench
========================================

// Module: ps2_kbd_cmd_sequencer
// PURPOSE
// - Host-side command sequencer for the PS/2 keyboard link; sits between game logic and PS2_Controller send/receive ports.
// - Runs keyboard reset/BAT after power-up, then services LED-update requests (ED + arg) with ACK checking, resend/timeout retry.
// - Consumes keyboard response bytes (FA/FE/AA/FC) while a command is open; forwards all other bytes to the scan-code decoder.
// PARAMETERS
// - RESP_TIMEOUT   500_000     cycles to wait for FA/FE after cmd_sent (10 ms @ 50 MHz)
// - BAT_TIMEOUT    37_500_000  cycles to wait for AA after reset ACK (750 ms @ 50 MHz)
// - MAX_RETRIES    3           resends allowed per byte before FAIL
// - TYPEMATIC_VAL  8'h20       F3 argument, used only with TYPEMATIC_CFG_EN
// PORTS
// - CLOCK_50     in   1  system clock
// - resetn       in   1  async active-low reset
// - cmd_data     out  8  byte to PS2_Controller (the_command)
// - cmd_send     out  1  1-cycle strobe, send cmd_data
// - cmd_sent     in   1  pulse: controller finished sending byte
// - cmd_err      in   1  pulse: controller send timed out
// - rx_data      in   8  received byte
// - rx_valid     in   1  1-cycle strobe, rx_data valid
// - fwd_data     out  8  forwarded byte to scan-code decoder
// - fwd_valid    out  1  1-cycle strobe, registered (1-cycle latency from rx_valid)
// - led_req      in   1  1-cycle request to update LEDs
// - led_val      in   3  {caps, num, scroll}, sampled with led_req
// - led_busy     out  1  LED update pending or in progress
// - led_done     out  1  1-cycle pulse, LED update ACKed
// - init_done    out  1  high once BAT passed (and typematic set)
// - fail         out  1  sticky, retry budget exhausted
// BEHAVIOUR
// - Reset values: cmd_data=00, cmd_send=0, fwd_*=0, led_busy=0, led_done=0, init_done=0, fail=0; state=RST_SEND.
// - Byte transaction (shared sub-sequence): SEND (cmd_send=1, one cycle) -> WAIT_SENT -> WAIT_RESP.
//   - WAIT_SENT: cmd_sent -> WAIT_RESP, timeout counter cleared; cmd_err -> retry.
//   - WAIT_RESP: rx FA -> success; FE -> retry; other byte -> forwarded, keep waiting; counter == RESP_TIMEOUT-1 -> retry.
//   - Retry: retry_cnt++, back to SEND with same byte; if retry_cnt == MAX_RETRIES already -> FAIL.
//   - retry_cnt cleared on every successful byte.
// - States: RST_SEND/RST_WAIT(FF) -> BAT_WAIT -> [TM_CMD(F3) -> TM_ARG(TYPEMATIC_VAL)] -> IDLE;
//   IDLE -> LED_CMD(ED) -> LED_ARG({5'b0,led_val}) -> IDLE.
// - BAT_WAIT: AA -> init_done=1 (or TM_CMD); FC -> retry FF; other byte forwarded; BAT_TIMEOUT -> retry FF.
// - Outside a response wait (IDLE, WAIT_SENT) every rx byte forwarded unchanged; FA/FE/AA in IDLE also forwarded.
// - LED requests: led_req in any non-FAIL state sets pending + latches led_val (latest wins); led_busy=1 same next cycle.
//   - IDLE with pending -> LED_CMD next cycle; pending cleared when LED_CMD entered.
//   - led_req during an active LED update re-arms pending; update repeats afterwards; led_done pulses per completion.
//   - led_req before init_done: held pending, serviced after init.
// - FAIL: cmd_send=0, fail=1, init_done=0, led_busy=0, led_req ignored; rx bytes still forwarded; exit only by reset.
// - Simultaneous cmd_sent & rx_valid: cmd_sent handled, rx byte forwarded. cmd_sent & cmd_err together: treat as error.
// - resetn low mid-transaction: all state cleared asynchronously; sequence restarts at RST_SEND on release.
// - Counters sized $clog2(BAT_TIMEOUT+1); one shared counter, cleared on each state entry.
// CONFIGURATION
// - TYPEMATIC_CFG_EN defined: after AA, send F3 then TYPEMATIC_VAL, each ACK-checked; init_done only after second FA.
// - Not defined: AA -> IDLE with init_done=1 directly; TYPEMATIC_VAL unused, no F3 ever sent.
// TESTING (bench with RESP_TIMEOUT=20, BAT_TIMEOUT=100, MAX_RETRIES=2)
// - Release reset; ack cmd_sent, rx FA, rx AA -> cmd_data=FF once, init_done=1 one cycle after AA, fwd_valid never high.
// - After init, led_req with led_val=3'b101; ack FA, FA -> sends ED then 05, led_done one pulse, led_busy low after.
// - Reply FE to ED twice then FA -> ED sent 3 times, update completes; fail=0.
// - Never answer FF (no rx after cmd_sent) -> 3 sends of FF 20 cycles apart, then fail=1, cmd_send stays 0.
// - During LED_ARG wait inject rx 1C then FA -> fwd_data=1C, fwd_valid one pulse, transaction completes.
// - led_req (3'b001) during LED_CMD of 3'b010 -> two updates, args 02 then 01, two led_done pulses.

Source files
------------

// File: rtl/ps2_kbd_cmd_sequencer_if.sv
// Signal bundle between the PS/2 keyboard command sequencer and its neighbours
// (PS2_Controller send/receive ports, scan-code decoder, game logic).
interface ps2_kbd_cmd_sequencer_if;
  logic [7:0] cmd_data;
  logic       cmd_send;
  logic       cmd_sent;
  logic       cmd_err;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] fwd_data;
  logic       fwd_valid;
  logic       led_req;
  logic [2:0] led_val;
  logic       led_busy;
  logic       led_done;
  logic       init_done;
  logic       fail;

  modport master (
    output cmd_data, cmd_send, fwd_data, fwd_valid, led_busy, led_done, init_done, fail,
    input  cmd_sent, cmd_err, rx_data, rx_valid, led_req, led_val
  );

  modport slave (
    input  cmd_data, cmd_send, fwd_data, fwd_valid, led_busy, led_done, init_done, fail,
    output cmd_sent, cmd_err, rx_data, rx_valid, led_req, led_val
  );
endinterface

// File: rtl/ps2_kbd_cmd_sequencer.sv
// Host-side PS/2 keyboard command sequencer: reset/BAT, optional typematic setup, LED updates.
// Optional feature macro: TYPEMATIC_CFG_EN (send F3 + TYPEMATIC_VAL after BAT).
module ps2_kbd_cmd_sequencer #(
  parameter int         RESP_TIMEOUT  = 500_000,
  parameter int         BAT_TIMEOUT   = 37_500_000,
  parameter int         MAX_RETRIES   = 3,
  parameter logic [7:0] TYPEMATIC_VAL = 8'h20
) (
  input  logic                          CLOCK_50,
  input  logic                          resetn,
  ps2_kbd_cmd_sequencer_if.master       bus
);
  localparam int CNT_W = $clog2(BAT_TIMEOUT + 1);
  localparam int RTY_W = $clog2(MAX_RETRIES + 2);

  typedef enum logic [2:0] {
    S_RST, S_BAT, S_TM_CMD, S_TM_ARG, S_IDLE, S_LED_CMD, S_LED_ARG, S_FAIL
  } state_e;
  typedef enum logic [1:0] {PH_SEND, PH_WAIT_SENT, PH_WAIT_RESP} phase_e;

  state_e             state_q, state_d;
  phase_e             ph_q, ph_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RTY_W-1:0]   rty_q, rty_d;
  logic               pend_q, pend_d;
  logic [2:0]         val_q, val_d;
  logic [2:0]         arg_q, arg_d;
  logic [7:0]         cmd_data_q, cmd_data_d;
  logic               cmd_send_q, cmd_send_d;
  logic [7:0]         fwd_data_q, fwd_data_d;
  logic               fwd_valid_q, fwd_valid_d;
  logic               led_busy_q, led_busy_d;
  logic               led_done_q, led_done_d;
  logic               init_done_q, init_done_d;
  logic               fail_q, fail_d;
  logic               is_cmd, do_retry, byte_ok, consume;
  logic [7:0]         tx_byte;

  always_comb begin
    state_d     = state_q;
    ph_d        = ph_q;
    cnt_d       = cnt_q;
    rty_d       = rty_q;
    pend_d      = pend_q;
    val_d       = val_q;
    arg_d       = arg_q;
    cmd_send_d  = 1'b0;
    cmd_data_d  = cmd_data_q;
    fwd_valid_d = 1'b0;
    fwd_data_d  = fwd_data_q;
    led_done_d  = 1'b0;
    do_retry    = 1'b0;
    byte_ok     = 1'b0;
    consume     = 1'b0;
    is_cmd      = state_q inside {S_RST, S_TM_CMD, S_TM_ARG, S_LED_CMD, S_LED_ARG};

    case (state_q)
      S_RST:     tx_byte = 8'hFF;
      S_TM_CMD:  tx_byte = 8'hF3;
      S_TM_ARG:  tx_byte = TYPEMATIC_VAL;
      S_LED_CMD: tx_byte = 8'hED;
      S_LED_ARG: tx_byte = {5'b0, arg_q};
      default:   tx_byte = 8'h00;
    endcase

    if (is_cmd) begin
      case (ph_q)
        PH_SEND: begin
          cmd_send_d = 1'b1;
          cmd_data_d = tx_byte;
          ph_d       = PH_WAIT_SENT;
        end
        PH_WAIT_SENT: begin
          // An error pulse wins over a simultaneous completion pulse.
          if (bus.cmd_err)       do_retry = 1'b1;
          else if (bus.cmd_sent) ph_d     = PH_WAIT_RESP;
        end
        default: begin
          if (bus.rx_valid && bus.rx_data == 8'hFA) begin
            consume = 1'b1;
            byte_ok = 1'b1;
          end else if (bus.rx_valid && bus.rx_data == 8'hFE) begin
            consume  = 1'b1;
            do_retry = 1'b1;
          end else if (cnt_q == CNT_W'(RESP_TIMEOUT - 1)) begin
            do_retry = 1'b1;
          end
        end
      endcase
    end else if (state_q == S_BAT) begin
      if (bus.rx_valid && bus.rx_data == 8'hAA) begin
        consume = 1'b1;
`ifdef TYPEMATIC_CFG_EN
        state_d = S_TM_CMD;
        ph_d    = PH_SEND;
`else
        state_d = S_IDLE;
`endif
      end else if (bus.rx_valid && bus.rx_data == 8'hFC) begin
        consume  = 1'b1;
        do_retry = 1'b1;
      end else if (cnt_q == CNT_W'(BAT_TIMEOUT - 1)) begin
        do_retry = 1'b1;
      end
    end else if (state_q == S_IDLE && pend_q) begin
      state_d = S_LED_CMD;
      ph_d    = PH_SEND;
      pend_d  = 1'b0;
      arg_d   = val_q;
    end

    if (byte_ok) begin
      rty_d = '0;
      ph_d  = PH_SEND;
      case (state_q)
        S_RST:     state_d = S_BAT;
        S_TM_CMD:  state_d = S_TM_ARG;
        S_LED_CMD: state_d = S_LED_ARG;
        S_LED_ARG: begin
          state_d    = S_IDLE;
          led_done_d = 1'b1;
        end
        default:   state_d = S_IDLE;
      endcase
    end

    // A failed BAT restarts the whole keyboard reset with FF.
    if (do_retry) begin
      if (rty_q == RTY_W'(MAX_RETRIES)) begin
        state_d = S_FAIL;
      end else begin
        rty_d = rty_q + 1'b1;
        ph_d  = PH_SEND;
        if (state_q == S_BAT) state_d = S_RST;
      end
    end

    if (bus.led_req && state_q != S_FAIL) begin
      pend_d = 1'b1;
      val_d  = bus.led_val;
    end

    if (bus.rx_valid && !consume) begin
      fwd_valid_d = 1'b1;
      fwd_data_d  = bus.rx_data;
    end

    if (state_d != state_q || ph_d != ph_q) cnt_d = '0;
    else if (cnt_q != '1)                   cnt_d = cnt_q + 1'b1;

    led_busy_d  = (state_d != S_FAIL) &&
                  (pend_d || state_d == S_LED_CMD || state_d == S_LED_ARG);
    init_done_d = state_d inside {S_IDLE, S_LED_CMD, S_LED_ARG};
    fail_d      = (state_d == S_FAIL);
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_RST;
      ph_q        <= PH_SEND;
      cnt_q       <= '0;
      rty_q       <= '0;
      pend_q      <= 1'b0;
      val_q       <= '0;
      arg_q       <= '0;
      cmd_data_q  <= '0;
      cmd_send_q  <= 1'b0;
      fwd_data_q  <= '0;
      fwd_valid_q <= 1'b0;
      led_busy_q  <= 1'b0;
      led_done_q  <= 1'b0;
      init_done_q <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ph_q        <= ph_d;
      cnt_q       <= cnt_d;
      rty_q       <= rty_d;
      pend_q      <= pend_d;
      val_q       <= val_d;
      arg_q       <= arg_d;
      cmd_data_q  <= cmd_data_d;
      cmd_send_q  <= cmd_send_d;
      fwd_data_q  <= fwd_data_d;
      fwd_valid_q <= fwd_valid_d;
      led_busy_q  <= led_busy_d;
      led_done_q  <= led_done_d;
      init_done_q <= init_done_d;
      fail_q      <= fail_d;
    end
  end

  assign bus.cmd_data  = cmd_data_q;
  assign bus.cmd_send  = cmd_send_q;
  assign bus.fwd_data  = fwd_data_q;
  assign bus.fwd_valid = fwd_valid_q;
  assign bus.led_busy  = led_busy_q;
  assign bus.led_done  = led_done_q;
  assign bus.init_done = init_done_q;
  assign bus.fail      = fail_q;
endmodule

// File: tb/tb_ps2_kbd_cmd_sequencer.sv
// Directed bench for ps2_kbd_cmd_sequencer (default build, typematic setup disabled).
`timescale 1ns/1ps
module tb_ps2_kbd_cmd_sequencer;
  localparam int RESP_TO = 20;
  localparam int BAT_TO  = 100;
  localparam int MAXR    = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0, n_pass = 0;
  int   send_cnt = 0, fwd_cnt = 0, done_cnt = 0, cyc = 0;

  ps2_kbd_cmd_sequencer_if bus();

  ps2_kbd_cmd_sequencer #(
    .RESP_TIMEOUT (RESP_TO),
    .BAT_TIMEOUT  (BAT_TO),
    .MAX_RETRIES  (MAXR),
    .TYPEMATIC_VAL(8'h20)
  ) dut (
    .CLOCK_50(clk),
    .resetn  (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.cmd_send)  send_cnt++;
    if (bus.fwd_valid) fwd_cnt++;
    if (bus.led_done)  done_cnt++;
  end

  typedef struct {
    logic [2:0] val;
    int         fe_cmd;
    int         fe_arg;
    int         exp_arg;
  } vec_t;

  vec_t vt[4];

  task automatic chk(input string nm, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
  endtask

  task automatic wait_send(output logic [7:0] b, output bit ok);
    ok = 1'b0;
    b  = 8'h00;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.cmd_send) begin
        b  = bus.cmd_data;
        ok = 1'b1;
        return;
      end
    end
    n_chk++;
    $display("FAIL cmd_send_wait: got no strobe expected strobe within 200 cycles");
  endtask

  task automatic pulse_sent();
    bus.cmd_sent = 1'b1;
    @(negedge clk);
    bus.cmd_sent = 1'b0;
  endtask

  task automatic rx_byte(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic led_request(input logic [2:0] v);
    bus.led_val = v;
    bus.led_req = 1'b1;
    @(negedge clk);
    bus.led_req = 1'b0;
  endtask

  task automatic serve_byte(input string nm, input int exp, input int n_fe, output int sends);
    logic [7:0] b;
    bit         ok;
    sends = 0;
    for (int a = 0; a <= n_fe; a++) begin
      wait_send(b, ok);
      if (!ok) return;
      sends++;
      chk(nm, int'(b), exp);
      pulse_sent();
      rx_byte(a < n_fe ? 8'hFE : 8'hFA);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] b;
    bit         ok;
    int         s0, d0, f0, ns, t_prev, t_now;

    vt[0] = '{val: 3'b101, fe_cmd: 0, fe_arg: 0, exp_arg: 'h05};
    vt[1] = '{val: 3'b010, fe_cmd: 2, fe_arg: 0, exp_arg: 'h02};
    vt[2] = '{val: 3'b111, fe_cmd: 0, fe_arg: 1, exp_arg: 'h07};
    vt[3] = '{val: 3'b000, fe_cmd: 1, fe_arg: 2, exp_arg: 'h00};

    bus.cmd_sent = 1'b0; bus.cmd_err = 1'b0;
    bus.rx_data  = 8'h00; bus.rx_valid = 1'b0;
    bus.led_req  = 1'b0; bus.led_val = 3'b000;

    repeat (3) @(negedge clk);
    chk("rst_cmd_data",  int'(bus.cmd_data), 0);
    chk("rst_cmd_send",  int'(bus.cmd_send), 0);
    chk("rst_fwd_valid", int'(bus.fwd_valid), 0);
    chk("rst_led_busy",  int'(bus.led_busy), 0);
    chk("rst_led_done",  int'(bus.led_done), 0);
    chk("rst_init_done", int'(bus.init_done), 0);
    chk("rst_fail",      int'(bus.fail), 0);
    rst_n = 1'b1;

    // Power-up: FF, ACK, BAT complete.
    wait_send(b, ok);
    chk("init_ff", int'(b), 'hFF);
    pulse_sent();
    rx_byte(8'hFA);
    chk("init_before_aa", int'(bus.init_done), 0);
    rx_byte(8'hAA);
    chk("init_after_aa", int'(bus.init_done), 1);
    repeat (2) @(negedge clk);
    chk("init_fwd_cnt",  fwd_cnt, 0);
    chk("init_send_cnt", send_cnt, 1);

    // Table of LED updates with FE retries on either byte.
    for (int v = 0; v < 4; v++) begin
      s0 = send_cnt;
      d0 = done_cnt;
      led_request(vt[v].val);
      chk($sformatf("v%0d_busy", v), int'(bus.led_busy), 1);
      serve_byte($sformatf("v%0d_ed", v), 'hED, vt[v].fe_cmd, ns);
      chk($sformatf("v%0d_ed_sends", v), ns, vt[v].fe_cmd + 1);
      serve_byte($sformatf("v%0d_arg", v), vt[v].exp_arg, vt[v].fe_arg, ns);
      chk($sformatf("v%0d_arg_sends", v), ns, vt[v].fe_arg + 1);
      repeat (3) @(negedge clk);
      chk($sformatf("v%0d_done_cnt", v), done_cnt - d0, 1);
      chk($sformatf("v%0d_busy_after", v), int'(bus.led_busy), 0);
      chk($sformatf("v%0d_fail", v), int'(bus.fail), 0);
      chk($sformatf("v%0d_total_sends", v), send_cnt - s0, vt[v].fe_cmd + vt[v].fe_arg + 2);
    end

    // Unrelated byte during the argument response wait is forwarded.
    f0 = fwd_cnt;
    d0 = done_cnt;
    led_request(3'b011);
    serve_byte("fw_ed", 'hED, 0, ns);
    wait_send(b, ok);
    chk("fw_arg", int'(b), 'h03);
    pulse_sent();
    rx_byte(8'h1C);
    chk("fw_valid", int'(bus.fwd_valid), 1);
    chk("fw_data",  int'(bus.fwd_data), 'h1C);
    rx_byte(8'hFA);
    repeat (3) @(negedge clk);
    chk("fw_cnt",  fwd_cnt - f0, 1);
    chk("fw_done", done_cnt - d0, 1);

    // Second request arriving while the first update is in its ED phase.
    d0 = done_cnt;
    led_request(3'b010);
    wait_send(b, ok);
    chk("rr_ed1", int'(b), 'hED);
    led_request(3'b001);
    pulse_sent();
    rx_byte(8'hFA);
    wait_send(b, ok);
    chk("rr_arg1", int'(b), 'h02);
    pulse_sent();
    rx_byte(8'hFA);
    serve_byte("rr_ed2", 'hED, 0, ns);
    serve_byte("rr_arg2", 'h01, 0, ns);
    repeat (3) @(negedge clk);
    chk("rr_done_cnt", done_cnt - d0, 2);
    chk("rr_busy", int'(bus.led_busy), 0);

    // Asynchronous reset mid-update, then a keyboard that never answers FF.
    led_request(3'b100);
    wait_send(b, ok);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_cmd_send",  int'(bus.cmd_send), 0);
    chk("ar_init_done", int'(bus.init_done), 0);
    chk("ar_led_busy",  int'(bus.led_busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    s0 = send_cnt;
    t_prev = 0;
    for (int k = 0; k < 3; k++) begin
      wait_send(b, ok);
      t_now = cyc;
      chk($sformatf("to_ff%0d", k), int'(b), 'hFF);
      if (k > 0) chk($sformatf("to_gap%0d", k), t_now - t_prev, RESP_TO + 2);
      t_prev = t_now;
      pulse_sent();
    end
    repeat (40) @(negedge clk);
    chk("to_fail",      int'(bus.fail), 1);
    chk("to_sends",     send_cnt - s0, 3);
    chk("to_cmd_send",  int'(bus.cmd_send), 0);
    chk("to_init_done", int'(bus.init_done), 0);
    led_request(3'b111);
    chk("to_led_ignored", int'(bus.led_busy), 0);
    rx_byte(8'h55);
    chk("to_fwd_valid", int'(bus.fwd_valid), 1);
    chk("to_fwd_data",  int'(bus.fwd_data), 'h55);
    repeat (5) @(negedge clk);
    chk("to_still_fail", int'(bus.fail), 1);
    chk("to_no_more_sends", send_cnt - s0, 3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
